or1200_lsu_dec_engine: RTL

- Load-path counterpart of the LSU store-side encryption engine.
- Sits between dcache load-return data and the LSU register-file writeback.
- Buffers keystream pads from the pad generator in a small FIFO, pairs each encrypted load with the oldest pad, XORs the size-selected lanes, and presents plaintext on a registered valid/ready output.
- Lane mapping matches the store side, so a store followed by a load of the same size round-trips.

---
 rtl/or1200_lsu_dec_engine_if.sv | 25 ++
 rtl/or1200_lsu_dec_engine.sv | 104 ++++++++++
 2 files changed

// File: rtl/or1200_lsu_dec_engine_if.sv
// Load-decrypt engine bus: pad input channel, encrypted load channel and plaintext output.
interface or1200_lsu_dec_engine_if;
  logic        pad_valid;
  logic        pad_ready;
  logic [31:0] pad_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [1:0]  ld_size;
  logic [31:0] ld_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  // Driver side: pad generator, dcache return path and writeback stage.
  modport master (
    output pad_valid, pad_data, ld_valid, ld_size, ld_data, out_ready,
    input  pad_ready, ld_ready, out_valid, out_data
  );

  // Engine side.
  modport slave (
    input  pad_valid, pad_data, ld_valid, ld_size, ld_data, out_ready,
    output pad_ready, ld_ready, out_valid, out_data
  );
endinterface

// File: rtl/or1200_lsu_dec_engine.sv
// LSU load-path decrypt engine: buffers keystream pads in a FIFO, XORs the
// size-selected lanes of each encrypted load with the oldest pad and presents
// the plaintext on a registered valid/ready output.
module or1200_lsu_dec_engine #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  or1200_lsu_dec_engine_if.slave bus,
  output logic [CW-1:0]          pad_count,
  output logic [15:0]            dec_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   padMem [DEPTH];
  logic [PW-1:0] wrPtrQ, rdPtrQ;
  logic [CW-1:0] padCountQ;
  logic          outValidQ;
  logic [31:0]   outDataQ;
  logic [15:0]   decCntQ;

  logic          isBypass, padAvail, push, fire, pop;
  logic [31:0]   headPad, decData;

  assign isBypass = (bus.ld_size == 2'b11);
  assign padAvail = (padCountQ != '0);
  assign headPad  = padMem[rdPtrQ];

  assign bus.pad_ready = !rst && !flush && (padCountQ != CW'(DEPTH));
  // Output register must be free or draining this cycle, and encrypted loads need a pad.
  assign bus.ld_ready  = !rst && !flush && (!outValidQ || bus.out_ready) && (isBypass || padAvail);

  assign push = bus.pad_valid && bus.pad_ready;
  assign fire = bus.ld_valid && bus.ld_ready;
  assign pop  = fire && !isBypass;

  assign bus.out_valid = outValidQ;
  assign bus.out_data  = outDataQ;
  assign pad_count     = padCountQ;
  assign dec_cnt       = decCntQ;

  // Lane select: pad is consumed from its top bits so it lines up with the store side.
  always_comb begin
    decData = bus.ld_data;
    unique case (bus.ld_size)
      2'b00:   decData = {bus.ld_data[31:8], bus.ld_data[7:0] ^ headPad[31:24]};
      2'b01:   decData = {bus.ld_data[31:16], bus.ld_data[15:0] ^ headPad[31:16]};
      2'b10:   decData = bus.ld_data ^ headPad;
      default: decData = bus.ld_data;
    endcase
  end

  // Pad storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      padMem[wrPtrQ] <= bus.pad_data;
    end
  end

  // FIFO pointers and occupancy; flush and reset both drop all buffered pads.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      padCountQ <= '0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + PW'(1);
      if (pop)  rdPtrQ <= rdPtrQ + PW'(1);
      if (push && !pop) begin
        padCountQ <= padCountQ + CW'(1);
      end else if (pop && !push) begin
        padCountQ <= padCountQ - CW'(1);
      end
    end
  end

  // Output register: loads on a fire, drops valid once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValidQ <= 1'b0;
      outDataQ  <= '0;
    end else if (flush) begin
      outValidQ <= 1'b0;
    end else if (fire) begin
      outValidQ <= 1'b1;
      outDataQ  <= decData;
    end else if (bus.out_ready) begin
      outValidQ <= 1'b0;
    end
  end

  // Saturating count of decrypted loads; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      decCntQ <= '0;
    end else if (pop && (decCntQ != 16'hFFFF)) begin
      decCntQ <= decCntQ + 16'd1;
    end
  end

endmodule
